// File: rtl/pixel_serializer_if.sv
// rtl/pixel_serializer_if.sv - glyph byte fetch and pixel output bundle for pixel_serializer
interface pixel_serializer_if;
    logic       pixEn;
    logic       lineStart;
    logic [7:0] inByte;
    logic       byteValid;
    logic       byteReq;
    logic [2:0] rgb;
    logic       pixActive;
    logic       underrun;
    logic       overrun;

    modport master (
        output pixEn, lineStart, inByte, byteValid,
        input  byteReq, rgb, pixActive, underrun, overrun
    );

    modport slave (
        input  pixEn, lineStart, inByte, byteValid,
        output byteReq, rgb, pixActive, underrun, overrun
    );
endinterface

// File: rtl/pixel_serializer.sv
// rtl/pixel_serializer.sv - glyph byte to rgb pixel serializer with hold/shift double buffer
// Define PIXEL_DOUBLE_EN to hold each glyph bit for two pixEn ticks.
module pixel_serializer #(
    parameter int         CHARS_PER_LINE = 80,
    parameter logic [2:0] FG_COLOR       = 3'b111,
    parameter logic [2:0] BG_COLOR       = 3'b000
) (
    input logic               clock,
    input logic               reset,
    pixel_serializer_if.slave vid
);
    localparam int CW = (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1;
    localparam int RW = $clog2(CHARS_PER_LINE + 1);
    localparam logic [CW-1:0] LAST_CHAR = CW'(CHARS_PER_LINE - 1);
    localparam logic [RW-1:0] REQ_MAX   = RW'(CHARS_PER_LINE);
`ifdef PIXEL_DOUBLE_EN
    localparam bit DOUBLE = 1'b1;
`else
    localparam bit DOUBLE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t         state;
    logic [7:0]     hold;
    logic           holdFull;
    logic [7:0]     shift;
    logic [2:0]     bitCnt;
    logic [CW-1:0]  charCnt;
    logic [RW-1:0]  reqCnt;
    logic           halfTick;
    logic           byteReq;
    logic [2:0]     rgb;
    logic           pixActive;
    logic           underrun;
    logic           overrun;

    logic advance;
    logic bitDone;
    logic reload;
    logic transfer;

    // In doubled mode the shift register only advances on the second tick of each bit.
    always_comb begin
        advance  = !DOUBLE || halfTick;
        bitDone  = (state == RUN) && vid.pixEn && advance && (bitCnt == 3'd0);
        reload   = bitDone && (charCnt != LAST_CHAR);
        transfer = ((state == FILL) && holdFull) || reload;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            hold      <= 8'h00;
            holdFull  <= 1'b0;
            shift     <= 8'h00;
            bitCnt    <= 3'd0;
            charCnt   <= '0;
            reqCnt    <= '0;
            halfTick  <= 1'b0;
            byteReq   <= 1'b0;
            rgb       <= BG_COLOR;
            pixActive <= 1'b0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            byteReq <= 1'b0;
            if (vid.lineStart) begin
                state     <= FILL;
                hold      <= 8'h00;
                holdFull  <= 1'b0;
                shift     <= 8'h00;
                bitCnt    <= 3'd0;
                charCnt   <= '0;
                halfTick  <= 1'b0;
                reqCnt    <= RW'(1);
                byteReq   <= 1'b1;
                rgb       <= BG_COLOR;
                pixActive <= 1'b0;
            end else begin
                // A byte arriving on a transfer cycle refills hold behind the outgoing byte.
                if (transfer) begin
                    hold     <= vid.byteValid ? vid.inByte : 8'h00;
                    holdFull <= vid.byteValid;
                    if (reqCnt != REQ_MAX) begin
                        byteReq <= 1'b1;
                        reqCnt  <= reqCnt + 1'b1;
                    end
                end else if (vid.byteValid) begin
                    if (!holdFull) begin
                        hold     <= vid.inByte;
                        holdFull <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end

                case (state)
                    IDLE: begin
                        if (vid.pixEn) begin
                            rgb       <= BG_COLOR;
                            pixActive <= 1'b0;
                        end
                    end
                    FILL: begin
                        if (vid.pixEn) begin
                            rgb       <= BG_COLOR;
                            pixActive <= 1'b0;
                        end
                        if (holdFull) begin
                            shift    <= hold;
                            bitCnt   <= 3'd7;
                            charCnt  <= '0;
                            halfTick <= 1'b0;
                            state    <= RUN;
                        end
                    end
                    RUN: begin
                        if (vid.pixEn) begin
                            rgb       <= shift[7] ? FG_COLOR : BG_COLOR;
                            pixActive <= 1'b1;
                            halfTick  <= DOUBLE ? ~halfTick : 1'b0;
                            if (advance) begin
                                if (bitCnt != 3'd0) begin
                                    shift  <= shift << 1;
                                    bitCnt <= bitCnt - 3'd1;
                                end else if (reload) begin
                                    shift   <= holdFull ? hold : 8'h00;
                                    bitCnt  <= 3'd7;
                                    charCnt <= charCnt + 1'b1;
                                    if (!holdFull)
                                        underrun <= 1'b1;
                                end else begin
                                    shift <= shift << 1;
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign vid.byteReq   = byteReq;
    assign vid.rgb       = rgb;
    assign vid.pixActive = pixActive;
    assign vid.underrun  = underrun;
    assign vid.overrun   = overrun;
endmodule

// File: doc/pixel_serializer.md
PIXEL_SERIALIZER -- requirements
Module: pixel_serializer

Interface
REQ-001 SHALL have parameter CHARS_PER_LINE, default 80: glyph bytes serialized per visible line.
REQ-002 SHALL have parameter FG_COLOR, default 3'b111: rgb value driven for a set glyph bit.
REQ-003 SHALL have parameter BG_COLOR, default 3'b000: rgb value driven for a clear glyph bit and for blanking.
REQ-004 SHALL have port clock  input  1  system clock; the only clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pixEn  input  1  one-cycle pixel tick; all pixel advance occurs only on cycles with pixEn=1.
REQ-007 SHALL have port lineStart  input  1  one-cycle pulse starting a visible character row.
REQ-008 SHALL have port inByte  input  8  glyph row byte from the ROM controller; MSB is the leftmost pixel.
REQ-009 SHALL have port byteValid  input  1  inByte is valid this cycle.
REQ-010 SHALL have port byteReq  output  1  one-cycle fetch strobe for the next glyph byte.
REQ-011 SHALL have port rgb  output  3  registered pixel colour.
REQ-012 SHALL have port pixActive  output  1  high while serialized pixels are being driven.
REQ-013 SHALL have port underrun  output  1  sticky flag: a byte was needed but the hold register was empty.
REQ-014 SHALL have port overrun  output  1  sticky flag: byteValid arrived while the hold register was full.

Function
REQ-015 SHALL implement states IDLE, FILL, RUN: IDLE->FILL on lineStart; FILL->RUN when the hold register is full; RUN->IDLE after the last bit of char CHARS_PER_LINE-1 is emitted.
REQ-016 SHALL pulse byteReq for one cycle on the cycle after entering FILL and on each hold-to-shift transfer while fewer than CHARS_PER_LINE requests have been issued this line; at most CHARS_PER_LINE pulses per line.
REQ-017 SHALL capture inByte into an 8-bit hold register when byteValid=1 and hold is empty; if hold is full and no transfer occurs in that cycle, the byte SHALL be dropped and overrun set.
REQ-018 SHALL, on FILL->RUN, move hold into an 8-bit shift register, clear hold, set bit counter to 7, char counter to 0.
REQ-019 SHALL, in RUN on each pixEn, register rgb=FG_COLOR if shift[7]=1 else BG_COLOR, shift left by one, decrement bit counter.
REQ-020 SHALL, on a pixEn with bit counter 0 and char counter < CHARS_PER_LINE-1, reload shift from hold (clearing hold) and increment char counter; if hold is empty, load 8'h00 and set underrun.
REQ-021 SHALL accept simultaneous byteValid and hold-to-shift transfer in the same cycle: old hold moves to shift, new byte lands in hold, no overrun.
REQ-022 SHALL drive pixActive=1 on cycles where rgb holds a serialized pixel, from the first RUN pixEn through one pixEn after the final bit; otherwise rgb=BG_COLOR and pixActive=0.
REQ-023 SHALL hold rgb, counters and shift register unchanged on RUN cycles with pixEn=0.
REQ-024 SHALL, on lineStart in FILL or RUN, abort the line: clear hold, counters and shift register, enter FILL, and restart the byteReq count at zero.
REQ-025 SHALL clear underrun and overrun only on reset.

Reset
REQ-026 SHALL, while reset=0, asynchronously force state IDLE, hold/shift registers 8'h00, counters 0, byteReq=0, rgb=BG_COLOR, pixActive=0, underrun=0, overrun=0.
REQ-027 SHALL resume operation on the first clock edge after reset deasserts, waiting in IDLE for lineStart.

Configuration
REQ-028 SHALL support macro PIXEL_DOUBLE_EN: when defined, each glyph bit SHALL be held for two pixEn ticks (16 ticks per char); when undefined, one tick per bit (8 ticks per char).

Verification
REQ-029 SHALL test: reset=0 mid-RUN -> next cycle rgb=3'b000, pixActive=0, byteReq=0, flags 0, state IDLE.
REQ-030 SHALL test: CHARS_PER_LINE=2, lineStart, bytes 8'hA5 then 8'h3C returned 2 cycles after each byteReq, pixEn every cycle -> rgb sequence 7,0,7,0,0,7,0,7,0,0,7,7,7,7,0,0; exactly 2 byteReq pulses; flags 0.
REQ-031 SHALL test: second byte withheld -> second char emits eight BG_COLOR pixels and underrun=1 until reset.
REQ-032 SHALL test: two byteValid pulses with no transfer while hold full -> second byte dropped, overrun=1.
REQ-033 SHALL test: lineStart asserted at char 1 bit 3 -> line aborts, next byteReq pulse the following cycle, char count restarts at 0.
REQ-034 SHALL test: PIXEL_DOUBLE_EN defined, byte 8'h80 -> rgb=FG_COLOR for two pixEn ticks then BG_COLOR for fourteen.
